// File: rtl/uart_mmio_if.sv
// Data-memory style slave bus for the memory-mapped UART: request, write data,
// combinational read data and stall.
interface uart_mmio_if;
  logic        en;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall;

  modport master (output en, we, addr, wd, input rd, stall);
  modport slave  (input en, we, addr, wd, output rd, stall);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: DATA (addr[0]=0) / STATUS (addr[0]=1) registers.
// Optional `UART_LOOPBACK_EN feeds the receiver from the internal TX line and parks txd high.
module uart_mmio #(
  parameter int unsigned CLOCK_PER_HALF_BIT = 10
) (
  input  logic       clock,
  input  logic       resetn,
  uart_mmio_if.slave bus,
  input  logic       rxd,
  output logic       txd,
  output logic       tx_busy,
  output logic       rx_ready,
  output logic       ferr
);
  localparam int unsigned BIT_CLKS = 2 * CLOCK_PER_HALF_BIT;
  localparam int unsigned CW       = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCK_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic       sel_status;
  logic       stall_int;
  logic       accept;
  logic       wr_data;
  logic       rd_data;
  logic       wr_status;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       overrun;
  logic       ferr_sticky;
  logic       tx_line;
  logic       rx_src;

  assign sel_status = bus.addr[0];
  assign stall_int  = bus.en & ~sel_status & (bus.we ? tx_busy : ~rx_valid);
  assign accept     = bus.en & ~stall_int;
  assign wr_data    = accept &  bus.we & ~sel_status;
  assign rd_data    = accept & ~bus.we & ~sel_status;
  assign wr_status  = accept &  bus.we &  sel_status;

  assign bus.stall = stall_int;
  assign bus.rd    = !bus.en    ? '0 :
                     sel_status ? {28'b0, overrun, ferr_sticky, rx_valid, tx_busy} :
                                  {24'b0, rx_byte};

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.addr[31:1], bus.wd[31:8]};

`ifdef UART_LOOPBACK_EN
  assign rx_src = tx_line;
  assign txd    = 1'b1;
  logic unused_rxd;
  assign unused_rxd = rxd;
`else
  assign rx_src = rxd;
  assign txd    = tx_line;
`endif

  // Transmitter
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_tick;

  assign tx_tick = (tx_cnt == BIT_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_cnt <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (wr_data) begin
            tx_state <= TX_START;
            tx_shift <= bus.wd[7:0];
            tx_line  <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_state <= TX_DATA;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              tx_line  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_line  <= tx_shift[1];
            end
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_state <= TX_IDLE;
            tx_busy  <= 1'b0;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Receiver, sampling mid-bit on the synchronized line
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      ferr_sticky <= 1'b0;
      rx_ready    <= 1'b0;
      ferr        <= 1'b0;
    end else begin
      rx_s1    <= rx_src;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_ready <= 1'b0;
      ferr     <= 1'b0;
      rx_cnt   <= rx_cnt + 1'b1;
      if (rd_data) rx_valid <= 1'b0;
      if (wr_status) begin
        if (bus.wd[2]) ferr_sticky <= 1'b0;
        if (bus.wd[3]) overrun     <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev & ~rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Leave at mid-stop so an immediately following start edge is seen
          if (rx_cnt == BIT_LAST) begin
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_byte  <= rx_shift;
              rx_valid <= 1'b1;
              rx_ready <= 1'b1;
              if (rx_valid & ~rd_data) overrun <= 1'b1;
            end else begin
              ferr        <= 1'b1;
              ferr_sticky <= 1'b1;
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: stimulus pushes expected TX frames, read data and
// RX events into queues; independent monitors pop and compare as the DUT produces them.
module tb_uart_mmio;
  localparam int unsigned H   = 10;
  localparam int unsigned BIT = 2 * H;
  localparam int          TMO = 4000;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic rxd    = 1'b1;
  logic txd, tx_busy, rx_ready, ferr;

  uart_mmio_if bus();

  uart_mmio #(.CLOCK_PER_HALF_BIT(H)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (bus),
    .rxd      (rxd),
    .txd      (txd),
    .tx_busy  (tx_busy),
    .rx_ready (rx_ready),
    .ferr     (ferr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [1:0]  exp_ev[$];   // {ferr, rx_ready}

  // Reference model of the receive side, in register terms
  logic       m_valid, m_ovr, m_ferr;
  logic [7:0] m_byte;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] adr(input logic s);
    logic [31:0] a;
    a    = $urandom;
    a[0] = s;
    return a;
  endfunction

  task automatic m_rx_good(input logic [7:0] b);
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_byte  = b;
  endtask

  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, output int st);
    st = 0;
    @(posedge clock); #1;
    bus.en = 1'b1; bus.we = w; bus.addr = a; bus.wd = d;
    forever begin
      @(negedge clock);
      if (!bus.stall) break;
      st++;
      if (st >= TMO) break;
    end
    @(posedge clock); #1;
    bus.en = 1'b0; bus.we = 1'b0;
    if (st >= TMO) begin
      checks++; errors++;
      $display("FAIL bus_timeout actual=stalled required=accept addr=0x%0h", a);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e, output int st);
    logic [31:0] dropped;
    exp_rd.push_back(e);
    bus_xfer(1'b0, a, 32'h0, st);
    if (st >= TMO && exp_rd.size() > 0) dropped = exp_rd.pop_back();
  endtask

  task automatic read_status(input logic txb);
    int st;
    bus_read(adr(1'b1), {28'b0, m_ovr, m_ferr, m_valid, txb}, st);
    chk("status_nostall", st, 0);
  endtask

  task automatic read_data_expect(input logic [7:0] b);
    int st;
    bus_read(adr(1'b0), {24'b0, b}, st);
    chk("data_read_nostall", st, 0);
    m_valid = 1'b0;
  endtask

  task automatic write_status(input logic [31:0] d);
    int st;
    bus_xfer(1'b1, adr(1'b1), d, st);
    chk("status_write_nostall", st, 0);
    if (d[2]) m_ferr = 1'b0;
    if (d[3]) m_ovr  = 1'b0;
  endtask

  task automatic write_data(input logic [7:0] b, output int st);
    logic [31:0] d;
    d = $urandom;
    d[7:0] = b;
    exp_tx.push_back(b);
    bus_xfer(1'b1, adr(1'b0), d, st);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    exp_ev.push_back(stop ? 2'b01 : 2'b10);
    rxd = 1'b0; cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i]; cyc(BIT);
    end
    rxd = stop; cyc(BIT);
    rxd = 1'b1;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (tx_busy && n < TMO) begin
      @(negedge clock);
      n++;
    end
    if (n >= TMO) begin
      checks++; errors++;
      $display("FAIL tx_idle_timeout actual=busy required=idle");
    end
    cyc(5);
  endtask

  // Serial decoder: each bit window is sampled near both ends
  logic [9:0] early, late;
  initial begin : tx_mon
    logic [7:0] e;
    logic       aborted;
    forever begin
      @(negedge clock);
      if (resetn && txd === 1'b0) begin
        aborted  = 1'b0;
        early[0] = txd;
        for (int t = 1; t < 10 * BIT; t++) begin
          @(negedge clock);
          if (!resetn) aborted = 1'b1;
          if (t % BIT == 1)       early[t / BIT] = txd;
          if (t % BIT == BIT - 2) late[t / BIT]  = txd;
        end
        if (aborted) begin
          if (exp_tx.size() > 0) e = exp_tx.pop_front();
        end else if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_frame actual=0x%0h required=no_frame", early);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_frame_early", {22'b0, early}, {22'b0, 1'b1, e, 1'b0});
          chk("tx_frame_late",  {22'b0, late},  {22'b0, 1'b1, e, 1'b0});
        end
      end
    end
  end

  initial begin : busy_mon
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if (!resetn) n = 0;
      else if (tx_busy) n++;
      else begin
        if (n != 0) chk("tx_busy_len", n, 20 * H);
        n = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (bus.en && !bus.stall && !bus.we) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd actual=0x%0h required=no_read", bus.rd);
      end else chk("rd", bus.rd, exp_rd.pop_front());
    end
    if (rx_ready || ferr) begin
      if (exp_ev.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_event actual=%b required=none", {ferr, rx_ready});
      end else chk("rx_event", {30'b0, ferr, rx_ready}, {30'b0, exp_ev.pop_front()});
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          st;
    logic [7:0]  b, b2;
    int unsigned r;
    logic        stop;

    bus.en = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wd = '0;
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = '0;
    cyc(3);
    chk("in_reset_txd", txd, 1);
    resetn = 1'b1;
    cyc(100);
    chk("reset_txd", txd, 1);
    chk("reset_tx_busy", tx_busy, 0);
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_ferr", ferr, 0);
    chk("rd_zero_when_idle", bus.rd, 0);
    read_status(1'b0);

    // Transmit: 0x99 then two writes that stall until the line frees
    write_data(8'h99, st);
    chk("wr1_nostall", st, 0);
    read_status(1'b1);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      write_data(b, st);
      chk("wr_stall_while_busy", (st > 150 && st < 200), 1);
    end
    wait_tx_idle();

    // Good frames, starting with 0xAA
    for (int i = 0; i < 6; i++) begin
      b = (i == 0) ? 8'hAA : 8'($urandom);
      send_frame(b, 1'b1);
      m_rx_good(b);
      cyc(BIT);
      read_status(1'b0);
      read_data_expect(b);
      read_status(1'b0);
    end

    // Framing error
    send_frame(8'h55, 1'b0);
    m_ferr = 1'b1;
    cyc(BIT);
    read_status(1'b0);
    write_status(32'h4);
    read_status(1'b0);

    // DATA read before the byte arrives stalls until it lands
    b = 8'($urandom);
    fork
      begin
        cyc(30);
        send_frame(b, 1'b1);
      end
      begin
        bus_read(adr(1'b0), {24'b0, b}, st);
        chk("data_read_stalled", (st > 150), 1);
      end
    join
    cyc(BIT);
    read_status(1'b0);

    // Overrun: two unread frames
    b  = 8'($urandom);
    b2 = 8'($urandom);
    send_frame(b, 1'b1);
    m_rx_good(b);
    send_frame(b2, 1'b1);
    m_rx_good(b2);
    cyc(BIT);
    read_status(1'b0);
    read_data_expect(b2);
    read_status(1'b0);
    write_status(32'h8);
    read_status(1'b0);

    // Random mix of good/bad frames, reads and flag clears
    for (int i = 0; i < 10; i++) begin
      r    = $urandom;
      b    = 8'($urandom);
      stop = (r % 4) != 0;
      send_frame(b, stop);
      if (stop) m_rx_good(b);
      else m_ferr = 1'b1;
      cyc(BIT);
      if (r[4]) read_status(1'b0);
      if (r[5] && m_valid) read_data_expect(m_byte);
      if (r[6]) write_status($urandom);
      read_status(1'b0);
    end

    // Reset in the middle of a transmitted frame
    b = 8'($urandom);
    write_data(b, st);
    cyc(60);
    resetn = 1'b0;
    #1;
    chk("midreset_txd", txd, 1);
    chk("midreset_tx_busy", tx_busy, 0);
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    cyc(3);
    resetn = 1'b1;
    cyc(5);
    read_status(1'b0);

    cyc(BIT * 12);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("ev_queue_drained", exp_ev.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
